icache_direct: RTL and testbench

ICACHE_DIRECT -- requirements
Module: icache_direct

---
 rtl/icache_direct.sv | 152 +++++++++++++++
 tb/tb_icache_direct.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, one-word-per-line instruction cache with a zero-cycle hit
//   path and a blocking single-word refill from the memory controller.
//
//   Parameters
//     SETS        number of lines, power of two in 2..1024
//
//   Ports
//     CLK         rising-edge clock for all state
//     nRST        asynchronous active-low reset
//     imemREN     fetch request from the datapath
//     imemaddr    fetch byte address (bits [1:0] ignored)
//     ihit        fetch satisfied this cycle, imemload valid
//     imemload    instruction word to the datapath (0 when ihit=0)
//     iREN        read request to the memory controller (FILL only)
//     iaddr       word-aligned refill address (0 outside FILL)
//     iwait       memory controller busy; iload valid when iREN & !iwait
//     iload       read data from the memory controller
//     hit_count   saturating count of hit cycles
//     miss_count  saturating count of misses
// -----------------------------------------------------------------------------
module icache_direct #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [31:0]     miss_addr_reg;
   logic [31:0]     hit_cnt_reg;
   logic [31:0]     miss_cnt_reg;
   logic [SETS-1:0] valid_reg;
   logic [SETS-1:0] fill_sel;

   // Tag and data storage carry no reset; the valid bits alone decide hits.
   // The lookup is read combinationally to give the zero-cycle hit.
   logic [TW-1:0]   tag_mem  [SETS];
   logic [31:0]     data_mem [SETS];

   logic [IW-1:0]   lookup_index;
   logic [TW-1:0]   lookup_tag;
   logic [IW-1:0]   fill_index;
   logic [TW-1:0]   fill_tag;
   logic            lookup_match;
   logic            miss_start;
   logic            fill_done;

   assign lookup_index = imemaddr[IW+1:2];
   assign lookup_tag   = imemaddr[31:IW+2];
   assign fill_index   = miss_addr_reg[IW+1:2];
   assign fill_tag     = miss_addr_reg[31:IW+2];

   assign lookup_match = valid_reg[lookup_index] && (tag_mem[lookup_index] == lookup_tag);

   assign hit_count  = hit_cnt_reg;
   assign miss_count = miss_cnt_reg;

   // One-hot decode of the line being filled this cycle.
   for (genvar gi = 0; gi < SETS; gi++) begin : g_fill_sel
      assign fill_sel[gi] = fill_done && (fill_index == IW'(gi));
   end

   // Next-state and output logic. Outputs depend only on state and inputs,
   // so an asynchronous reset of state_reg/valid_reg clears them at once.
   always_comb begin
      state_next = state_reg;
      ihit       = 1'b0;
      imemload   = 32'h0;
      iREN       = 1'b0;
      iaddr      = 32'h0;
      miss_start = 1'b0;
      fill_done  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (imemREN) begin
               if (lookup_match) begin
                  ihit     = 1'b1;
                  imemload = data_mem[lookup_index];
               end else begin
                  miss_start = 1'b1;
                  state_next = FILL;
               end
            end
         end
         FILL: begin
            // The refill runs to completion on the latched address no
            // matter what the datapath does meanwhile.
            iREN  = 1'b1;
            iaddr = miss_addr_reg;
            if (!iwait) begin
               fill_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg     <= IDLE;
         miss_addr_reg <= 32'h0;
         hit_cnt_reg   <= 32'h0;
         miss_cnt_reg  <= 32'h0;
         valid_reg     <= '0;
      end else begin
         state_reg <= state_next;
         valid_reg <= valid_reg | fill_sel;
         if (miss_start) begin
            miss_addr_reg <= {imemaddr[31:2], 2'b00};
         end
         if (ihit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
         end
         if (miss_start && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
         end
      end
   end

   // Array write happens only in FILL and lookup only in IDLE, so the same
   // line is never read and written in one cycle. A reset forces IDLE
   // asynchronously, which suppresses any pending write.
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         tag_mem[fill_index]  <= fill_tag;
         data_mem[fill_index] <= iload;
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// -----------------------------------------------------------------------------
// tb_icache_direct
//   Directed bench for icache_direct (SETS=16). Stimulus pushes the expected
//   refill addresses and hit data into queues; a monitor pops and compares
//   whenever the cache presents a hit or a completed refill request.
// -----------------------------------------------------------------------------
module tb_icache_direct;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] hit_q[$];
   logic [31:0] fill_q[$];

   icache_direct #(.SETS(16)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs (called just after a rising edge) and move to the falling
   // edge where outputs are sampled.
   task automatic drive(input logic req, input logic [31:0] addr,
                        input logic w, input logic [31:0] ld);
      imemREN  = req;
      imemaddr = addr;
      iwait    = w;
      iload    = ld;
      @(negedge CLK);
   endtask

   task automatic next_edge();
      @(posedge CLK);
      #1;
   endtask

   // Miss, nwait stalled FILL cycles, completing FILL cycle, then a hit.
   task automatic do_miss(input logic [31:0] addr, input logic [31:0] data, input int nwait);
      fill_q.push_back(addr);
      drive(1'b1, addr, 1'b1, 32'h0);
      chk("miss_ihit", {31'b0, ihit}, 32'd0);
      chk("miss_iren", {31'b0, iREN}, 32'd0);
      next_edge();
      for (int i = 0; i < nwait; i++) begin
         drive(1'b1, addr, 1'b1, 32'hBAD0_0000);
         chk("stall_iren", {31'b0, iREN}, 32'd1);
         chk("stall_iaddr", iaddr, addr);
         chk("stall_ihit", {31'b0, ihit}, 32'd0);
         next_edge();
      end
      drive(1'b1, addr, 1'b0, data);
      chk("fill_iren", {31'b0, iREN}, 32'd1);
      next_edge();
      hit_q.push_back(data);
      drive(1'b1, addr, 1'b1, 32'hDEAD_BEEF);
      chk("after_fill_ihit", {31'b0, ihit}, 32'd1);
      chk("after_fill_iren", {31'b0, iREN}, 32'd0);
      next_edge();
   endtask

   // Monitor: one line per transaction, compares against the queues.
   always @(negedge CLK) begin
      if (nRST) begin
         if (ihit) begin
            if (hit_q.size() == 0) begin
               chk("unexpected_hit", imemload, 32'hFFFF_FFFF);
            end else begin
               logic [31:0] exp_d;
               exp_d = hit_q.pop_front();
               $display("[MON] hit  addr=0x%08h data=0x%08h exp=0x%08h", imemaddr, imemload, exp_d);
               chk("hit_data", imemload, exp_d);
            end
         end else begin
            chk("load_zero_on_nohit", imemload, 32'h0);
         end
         if (iREN && !iwait) begin
            if (fill_q.size() == 0) begin
               chk("unexpected_fill", iaddr, 32'hFFFF_FFFF);
            end else begin
               logic [31:0] exp_a;
               exp_a = fill_q.pop_front();
               $display("[MON] fill iaddr=0x%08h iload=0x%08h exp_addr=0x%08h", iaddr, iload, exp_a);
               chk("fill_addr", iaddr, exp_a);
            end
         end
      end
   end

   initial begin
      nRST     = 1'b1;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      iwait    = 1'b1;
      iload    = 32'h0;
      #3 nRST = 1'b0;

      // Reset state
      @(negedge CLK);
      chk("rst_ihit", {31'b0, ihit}, 32'd0);
      chk("rst_iren", {31'b0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'h0);
      chk("rst_imemload", imemload, 32'h0);
      chk("rst_hit_count", hit_count, 32'h0);
      chk("rst_miss_count", miss_count, 32'h0);
      next_edge();
      nRST = 1'b1;

      // Idle with no request: nothing happens
      drive(1'b0, 32'h0000_0040, 1'b1, 32'h0);
      chk("idle_iren", {31'b0, iREN}, 32'd0);
      chk("idle_ihit", {31'b0, ihit}, 32'd0);
      next_edge();
      chk("idle_miss_count", miss_count, 32'h0);

      // Cold miss with 3 stall cycles, then hold the address for 5 more hits
      do_miss(32'h0000_0040, 32'h2001_0005, 3);
      chk("cold_miss_count", miss_count, 32'd1);
      for (int k = 0; k < 5; k++) begin
         hit_q.push_back(32'h2001_0005);
         drive(1'b1, 32'h0000_0040, 1'b1, 32'h0);
         chk("hold_hit_count", hit_count, 32'(k + 1));
         chk("hold_iren", {31'b0, iREN}, 32'd0);
         next_edge();
      end
      chk("hold_hit_total", hit_count, 32'd6);

      // Conflict on index 0: 0x80 evicts 0x40, then 0x40 misses again
      do_miss(32'h0000_0080, 32'hAAAA_0080, 0);
      do_miss(32'h0000_0040, 32'h2001_0005, 1);
      chk("conflict_miss_count", miss_count, 32'd3);

      // Address change mid-fill: refill of 0x100 continues, then 0x200 misses
      fill_q.push_back(32'h0000_0100);
      drive(1'b1, 32'h0000_0100, 1'b1, 32'h0);
      chk("chg_miss_ihit", {31'b0, ihit}, 32'd0);
      next_edge();
      drive(1'b1, 32'h0000_0200, 1'b1, 32'h0);
      chk("chg_iaddr_stall", iaddr, 32'h0000_0100);
      next_edge();
      drive(1'b1, 32'h0000_0200, 1'b0, 32'h1111_0100);
      chk("chg_iaddr_fill", iaddr, 32'h0000_0100);
      next_edge();
      do_miss(32'h0000_0200, 32'h2222_0200, 0);
      chk("chg_miss_count", miss_count, 32'd5);

      // Request dropped mid-fill (index 1): line still written, hit later
      fill_q.push_back(32'h0000_0104);
      drive(1'b1, 32'h0000_0104, 1'b1, 32'h0);
      next_edge();
      drive(1'b0, 32'h0000_0208, 1'b0, 32'h4444_0104);
      chk("drop_iren", {31'b0, iREN}, 32'd1);
      chk("drop_iaddr", iaddr, 32'h0000_0104);
      next_edge();
      drive(1'b0, 32'h0000_0208, 1'b1, 32'h0);
      chk("drop_idle_iren", {31'b0, iREN}, 32'd0);
      chk("drop_idle_iaddr", iaddr, 32'h0);
      next_edge();
      chk("drop_miss_count", miss_count, 32'd6);
      hit_q.push_back(32'h4444_0104);
      drive(1'b1, 32'h0000_0104, 1'b1, 32'h0);
      chk("drop_hit", {31'b0, ihit}, 32'd1);
      next_edge();

      // Reset asserted during FILL
      drive(1'b1, 32'h0000_0300, 1'b1, 32'h0);
      next_edge();
      drive(1'b1, 32'h0000_0300, 1'b1, 32'h0);
      chk("pre_rst_iren", {31'b0, iREN}, 32'd1);
      #1 nRST = 1'b0;
      #1;
      chk("midrst_iren", {31'b0, iREN}, 32'd0);
      chk("midrst_iaddr", iaddr, 32'h0);
      chk("midrst_hit_count", hit_count, 32'h0);
      chk("midrst_miss_count", miss_count, 32'h0);
      next_edge();
      next_edge();
      nRST = 1'b1;
      // 0x104 was valid before reset; it must now miss
      drive(1'b1, 32'h0000_0104, 1'b1, 32'h0);
      chk("cold_after_rst_ihit", {31'b0, ihit}, 32'd0);
      imemREN = 1'b0;
      next_edge();
      next_edge();
      do_miss(32'h0000_0100, 32'h3333_0100, 0);
      chk("post_rst_miss_count", miss_count, 32'd1);
      chk("post_rst_hit_count", hit_count, 32'd1);

      // Saturation of hit_count
      drive(1'b0, 32'h0000_0100, 1'b1, 32'h0);
      force dut.hit_cnt_reg = 32'hFFFF_FFFE;
      #1 release dut.hit_cnt_reg;
      next_edge();
      chk("sat_preload", hit_count, 32'hFFFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         hit_q.push_back(32'h3333_0100);
         drive(1'b1, 32'h0000_0100, 1'b1, 32'h0);
         next_edge();
         chk("sat_hit_count", hit_count, 32'hFFFF_FFFF);
      end

      drive(1'b0, 32'h0, 1'b1, 32'h0);
      next_edge();
      chk("hit_q_drained", 32'(hit_q.size()), 32'd0);
      chk("fill_q_drained", 32'(fill_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
